// File: rtl/bridge_pkg.sv
// Shared types for the queued core-to-DRAM bridge.
// FSM state encoding and AXI response helpers.
package bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        OUT
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // SLVERR and DECERR both carry bit 1; EXOKAY does not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp & RESP_SLVERR) != RESP_OKAY;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Generic synchronous FIFO for queued core commands.
// Pointers carry an extra wrap bit to tell full from empty.
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_q;
    logic [PW:0]      rd_q;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[PW] != rd_q[PW]) &&
                   (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign dout  = mem_q[rd_q[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push && !full)
                wr_q <= wr_q + 1'b1;
            if (pop && !empty)
                rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem_q[wr_q[PW-1:0]] <= din;
    end

endmodule

// File: rtl/bridge_queued.sv
// Queued core-to-DRAM bridge: core requests become AXI4-Lite
// AR/R or AW/W/B transactions, one outstanding, strictly in order.
module bridge_queued
    import bridge_pkg::*;
#(
    parameter int               DATA_W     = 64,
    parameter int               IDX_W      = 8,
    parameter int               ADDR_W     = 17,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h10000,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              C_in_valid,
    output logic              C_in_ready,
    input  logic              C_r_wb,
    input  logic [IDX_W-1:0]  C_addr,
    input  logic [DATA_W-1:0] C_data_w,
    output logic              C_out_valid,
    output logic [DATA_W-1:0] C_data_r,
    output logic              C_err,
    output logic              AR_VALID,
    input  logic              AR_READY,
    output logic [ADDR_W-1:0] AR_ADDR,
    input  logic              R_VALID,
    output logic              R_READY,
    input  logic [DATA_W-1:0] R_DATA,
    input  logic [1:0]        R_RESP,
    output logic              AW_VALID,
    input  logic              AW_READY,
    output logic [ADDR_W-1:0] AW_ADDR,
    output logic              W_VALID,
    input  logic              W_READY,
    output logic [DATA_W-1:0] W_DATA,
    input  logic              B_VALID,
    output logic              B_READY,
    input  logic [1:0]        B_RESP
);
    localparam int SHIFT = $clog2(DATA_W / 8);
    localparam int OFF_W = IDX_W + SHIFT;

    typedef struct packed {
        logic              r_wb;
        logic [IDX_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    cmd_t push_cmd;
    cmd_t head;
    logic fifo_full;
    logic fifo_empty;
    logic pop;

    state_t            state_q;
    logic              ar_valid_q;
    logic [ADDR_W-1:0] ar_addr_q;
    logic              aw_valid_q;
    logic [ADDR_W-1:0] aw_addr_q;
    logic              w_valid_q;
    logic [DATA_W-1:0] w_data_q;
    logic              r_ready_q;
    logic              b_ready_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] data_r_q;
    logic              err_q;
    logic              aw_done_q;
    logic              w_done_q;

    logic [OFF_W-1:0]  head_off;
    logic [ADDR_W-1:0] head_addr;
    logic              aw_hs;
    logic              w_hs;
    logic              aw_fin;
    logic              w_fin;

    assign push_cmd = '{r_wb: C_r_wb, addr: C_addr, data: C_data_w};
    assign pop      = (state_q == IDLE) && !fifo_empty;

    cmd_fifo #(
        .WIDTH($bits(cmd_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (C_in_valid),
        .pop  (pop),
        .din  (push_cmd),
        .dout (head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign head_off  = OFF_W'(head.addr) << SHIFT;
    assign head_addr = BASE_ADDR + ADDR_W'(head_off);

    // A handshake this cycle counts as done for the WR_RESP decision.
    assign aw_hs  = aw_valid_q && AW_READY;
    assign w_hs   = w_valid_q && W_READY;
    assign aw_fin = aw_done_q || aw_hs;
    assign w_fin  = w_done_q || w_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ar_valid_q  <= 1'b0;
            ar_addr_q   <= '0;
            aw_valid_q  <= 1'b0;
            aw_addr_q   <= '0;
            w_valid_q   <= 1'b0;
            w_data_q    <= '0;
            r_ready_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            out_valid_q <= 1'b0;
            data_r_q    <= '0;
            err_q       <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (head.r_wb) begin
                            ar_valid_q <= 1'b1;
                            ar_addr_q  <= head_addr;
                            state_q    <= RD_ADDR;
                        end else begin
                            aw_valid_q <= 1'b1;
                            aw_addr_q  <= head_addr;
                            w_valid_q  <= 1'b1;
                            w_data_q   <= head.data;
                            aw_done_q  <= 1'b0;
                            w_done_q   <= 1'b0;
                            state_q    <= WR_REQ;
                        end
                    end
                end
                RD_ADDR: begin
                    if (AR_READY) begin
                        ar_valid_q <= 1'b0;
                        ar_addr_q  <= '0;
                        r_ready_q  <= 1'b1;
                        state_q    <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (R_VALID) begin
                        r_ready_q   <= 1'b0;
                        data_r_q    <= R_DATA;
                        err_q       <= resp_is_err(R_RESP);
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        aw_valid_q <= 1'b0;
                        aw_addr_q  <= '0;
                        aw_done_q  <= 1'b1;
                    end
                    if (w_hs) begin
                        w_valid_q <= 1'b0;
                        w_data_q  <= '0;
                        w_done_q  <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        b_ready_q <= 1'b1;
                        state_q   <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (B_VALID) begin
                        b_ready_q   <= 1'b0;
                        data_r_q    <= '0;
                        err_q       <= resp_is_err(B_RESP);
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                OUT: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign C_in_ready  = !fifo_full;
    assign C_out_valid = out_valid_q;
    assign C_data_r    = data_r_q;
    assign C_err       = err_q;
    assign AR_VALID    = ar_valid_q;
    assign AR_ADDR     = ar_addr_q;
    assign R_READY     = r_ready_q;
    assign AW_VALID    = aw_valid_q;
    assign AW_ADDR     = aw_addr_q;
    assign W_VALID     = w_valid_q;
    assign W_DATA      = w_data_q;
    assign B_READY     = b_ready_q;

endmodule

// File: tb/tb_bridge_queued.sv
// Scoreboard bench for bridge_queued with a scripted AXI slave.
// Completions and bus beats are checked by free-running monitors.
module tb_bridge_queued;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        C_in_valid = 1'b0;
    logic        C_in_ready;
    logic        C_r_wb = 1'b0;
    logic [7:0]  C_addr = '0;
    logic [63:0] C_data_w = '0;
    logic        C_out_valid;
    logic [63:0] C_data_r;
    logic        C_err;
    logic        AR_VALID, AR_READY;
    logic [16:0] AR_ADDR;
    logic        R_VALID = 1'b0, R_READY;
    logic [63:0] R_DATA = '0;
    logic [1:0]  R_RESP = '0;
    logic        AW_VALID, AW_READY;
    logic [16:0] AW_ADDR;
    logic        W_VALID, W_READY;
    logic [63:0] W_DATA;
    logic        B_VALID = 1'b0, B_READY;
    logic [1:0]  B_RESP = '0;

    bit ar_en = 0, aw_en = 0, w_en = 0, r_en = 0, b_en = 0;
    assign AR_READY = ar_en;
    assign AW_READY = aw_en;
    assign W_READY  = w_en;

    always #5 clk = ~clk;

    bridge_queued dut (
        .clk(clk), .rst_n(rst_n),
        .C_in_valid(C_in_valid), .C_in_ready(C_in_ready),
        .C_r_wb(C_r_wb), .C_addr(C_addr), .C_data_w(C_data_w),
        .C_out_valid(C_out_valid), .C_data_r(C_data_r), .C_err(C_err),
        .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
        .R_VALID(R_VALID), .R_READY(R_READY),
        .R_DATA(R_DATA), .R_RESP(R_RESP),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
        .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP)
    );

    typedef struct {
        logic [63:0] d;
        logic        e;
        int          acc;
        bit          lat;
        bit          gap;
    } exp_t;
    typedef struct {
        logic [63:0] d;
        logic [1:0]  r;
    } rd_t;

    exp_t        sb[$];
    rd_t         rq[$];
    logic [1:0]  bq[$];
    logic [16:0] ar_q[$];
    logic [16:0] aw_q[$];
    logic [63:0] w_q[$];

    int   checks = 0, errors = 0;
    int   cyc = 0, last_out = 0, n_out = 0, b_cnt = 0;
    bit   r_pend = 0, b_pend = 0, prev_any = 0;
    exp_t em;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave: presents the head of its response queues, pops after a handshake.
    always @(negedge clk) begin
        if (r_pend && rq.size() != 0) void'(rq.pop_front());
        if (b_pend && bq.size() != 0) begin
            void'(bq.pop_front());
            b_cnt++;
        end
        R_VALID = r_en && rq.size() != 0;
        R_DATA  = R_VALID ? rq[0].d : 64'h0;
        R_RESP  = R_VALID ? rq[0].r : 2'b00;
        B_VALID = b_en && bq.size() != 0;
        B_RESP  = B_VALID ? bq[0] : 2'b00;
        r_pend  = R_VALID && R_READY;
        b_pend  = B_VALID && B_READY;
    end

    always @(negedge clk) if (rst_n) begin
        if (C_out_valid) begin
            checks++;
            n_out++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_completion data=%h err=%b", C_data_r, C_err);
            end else begin
                em = sb.pop_front();
                if (C_data_r !== em.d || C_err !== em.e) begin
                    errors++;
                    $display("FAIL completion got %h/%b want %h/%b",
                             C_data_r, C_err, em.d, em.e);
                end
                if (em.lat) begin
                    checks++;
                    if (cyc - em.acc != 3) begin
                        errors++;
                        $display("FAIL latency got %0d want 3", cyc - em.acc);
                    end
                end
                if (em.gap) begin
                    checks++;
                    if (cyc - last_out != 4) begin
                        errors++;
                        $display("FAIL b2b_gap got %0d want 4", cyc - last_out);
                    end
                end
            end
            last_out = cyc;
        end
        if (AR_VALID && AR_READY) begin
            checks++;
            if (ar_q.size() == 0) begin
                errors++;
                $display("FAIL ar_unexpected addr=%h", AR_ADDR);
            end else begin
                if (AR_ADDR !== ar_q[0]) begin
                    errors++;
                    $display("FAIL ar_addr got %h want %h", AR_ADDR, ar_q[0]);
                end
                void'(ar_q.pop_front());
            end
        end
        if (AW_VALID && AW_READY) begin
            checks++;
            if (aw_q.size() == 0) begin
                errors++;
                $display("FAIL aw_unexpected addr=%h", AW_ADDR);
            end else begin
                if (AW_ADDR !== aw_q[0]) begin
                    errors++;
                    $display("FAIL aw_addr got %h want %h", AW_ADDR, aw_q[0]);
                end
                void'(aw_q.pop_front());
            end
        end
        if (W_VALID && W_READY) begin
            checks++;
            if (w_q.size() == 0) begin
                errors++;
                $display("FAIL w_unexpected data=%h", W_DATA);
            end else begin
                if (W_DATA !== w_q[0]) begin
                    errors++;
                    $display("FAIL w_data got %h want %h", W_DATA, w_q[0]);
                end
                void'(w_q.pop_front());
            end
        end
        checks++;
        if ((!AR_VALID && AR_ADDR != 0) || (!AW_VALID && AW_ADDR != 0) ||
            (!W_VALID && W_DATA != 0)) begin
            errors++;
            $display("FAIL idle_bus_zero ar=%h aw=%h w=%h want 0",
                     AR_ADDR, AW_ADDR, W_DATA);
        end
        if ((AW_VALID || W_VALID) && !prev_any) begin
            checks++;
            if (!(AW_VALID && W_VALID)) begin
                errors++;
                $display("FAIL aw_w_together aw=%b w=%b want 1/1", AW_VALID, W_VALID);
            end
        end
        prev_any = AW_VALID || W_VALID;
    end

    task automatic send(input bit rwb, input logic [7:0] a,
                        input logic [63:0] d, input logic [16:0] ea,
                        input logic [1:0] resp, input logic [63:0] rd,
                        input bit lat, input bit gap);
        exp_t e;
        bit   ok = 0;
        if (rwb) rq.push_back('{d: rd, r: resp});
        else bq.push_back(resp);
        C_in_valid = 1'b1;
        C_r_wb     = rwb;
        C_addr     = a;
        C_data_w   = d;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (C_in_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout addr=%h ready=%b want 1", a, C_in_ready);
        end else begin
            e.d   = rwb ? rd : 64'h0;
            e.e   = resp[1];
            e.acc = cyc;
            e.lat = lat;
            e.gap = gap;
            sb.push_back(e);
            if (rwb) ar_q.push_back(ea);
            else begin
                aw_q.push_back(ea);
                w_q.push_back(d);
            end
        end
        C_in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s drain_timeout pending=%0d want 0", nm, sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_rst(input string nm);
        checks++;
        if ({C_in_ready, C_out_valid, AR_VALID, AW_VALID, W_VALID,
             R_READY, B_READY, C_err} !== 8'b1000_0000 ||
            C_data_r !== 64'h0 || AR_ADDR !== 17'h0 ||
            AW_ADDR !== 17'h0 || W_DATA !== 64'h0) begin
            errors++;
            $display("FAIL %s rdy=%b ov=%b ar=%b aw=%b w=%b rr=%b br=%b err=%b dr=%h want 1,0...",
                     nm, C_in_ready, C_out_valid, AR_VALID, AW_VALID,
                     W_VALID, R_READY, B_READY, C_err, C_data_r);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int b0;
        int n0;
        repeat (2) @(negedge clk);
        chk_rst("reset_state");
        #1 rst_n = 1'b1;
        ar_en = 1; aw_en = 1; w_en = 1; r_en = 1; b_en = 1;
        @(posedge clk);
        #1;

        send(1, 8'h05, 64'h0, 17'h10028, 2'b00, 64'hDEAD_BEEF_0123_4567, 1, 0);
        drain("read_zero_wait");

        send(0, 8'hFF, 64'h1, 17'h107F8, 2'b00, 64'h0, 1, 0);
        drain("write_max_idx");

        w_en = 0;
        b0 = b_cnt;
        send(0, 8'h20, 64'hABC, 17'h10100, 2'b00, 64'h0, 0, 0);
        repeat (4) @(negedge clk);
        checks++;
        if (AW_VALID !== 1'b0 || W_VALID !== 1'b1) begin
            errors++;
            $display("FAIL aw_early aw=%b w=%b want 0/1", AW_VALID, W_VALID);
        end
        @(posedge clk);
        #1 w_en = 1;
        drain("aw_before_w");
        repeat (3) @(negedge clk);
        checks++;
        if (b_cnt - b0 != 1) begin
            errors++;
            $display("FAIL b_count got %0d want 1", b_cnt - b0);
        end
        @(posedge clk);
        #1;

        ar_en = 0;
        for (int k = 0; k < 5; k++)
            send(1, 8'(8'h10 + k), 64'h0, 17'(17'h10080 + 8 * k), 2'b00,
                 64'h1111_0000_0000_0000 + 64'(k), 0, k != 0);
        checks++;
        if (C_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready got %b want 0", C_in_ready);
        end
        fork
            send(1, 8'h15, 64'h0, 17'h100A8, 2'b00, 64'h1111_0000_0000_0005, 0, 1);
        join_none
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (C_in_ready !== 1'b0 || sb.size() != 5) begin
            errors++;
            $display("FAIL full_hold ready=%b queued=%0d want 0/5", C_in_ready, sb.size());
        end
        ar_en = 1;
        drain("stall_queue");

        send(0, 8'h02, 64'h55, 17'h10010, 2'b10, 64'h0, 0, 0);
        send(1, 8'h03, 64'h0, 17'h10018, 2'b00, 64'h0123_4567_89AB_CDEF, 0, 0);
        drain("err_then_ok");

        r_en = 0;
        send(1, 8'h01, 64'h0, 17'h10008, 2'b00, 64'hBAD, 0, 0);
        send(0, 8'h06, 64'h66, 17'h10030, 2'b00, 64'h0, 0, 0);
        send(0, 8'h07, 64'h77, 17'h10038, 2'b00, 64'h0, 0, 0);
        for (int i = 0; i < 50 && !R_READY; i++) @(negedge clk);
        checks++;
        if (R_READY !== 1'b1) begin
            errors++;
            $display("FAIL rd_data_reach r_ready=%b want 1", R_READY);
        end
        #1 rst_n = 1'b0;
        #1 chk_rst("reset_mid_txn");
        sb.delete(); rq.delete(); bq.delete();
        ar_q.delete(); aw_q.delete(); w_q.delete();
        r_pend = 0; b_pend = 0;
        n0 = n_out;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        r_en = 1;
        repeat (20) @(negedge clk);
        checks++;
        if (n_out != n0 || C_in_ready !== 1'b1 || AR_VALID !== 1'b0 || AW_VALID !== 1'b0) begin
            errors++;
            $display("FAIL post_reset outs=%0d rdy=%b ar=%b aw=%b want 0/1/0/0",
                     n_out - n0, C_in_ready, AR_VALID, AW_VALID);
        end

        checks++;
        if (ar_q.size() + aw_q.size() + w_q.size() + sb.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect got %0d want 0",
                     ar_q.size() + aw_q.size() + w_q.size() + sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
